// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port sequencer for a single-port memory with registered one-cycle read latency
module mem_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    err,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;
  logic last, id, we_l, oor;
  logic sel, sel_we, sel_oor;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  always_comb begin
    sel = (req == 2'b11) ? ~last : req[1];
    sel_addr = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    sel_we = we[sel];
    sel_oor = sel_addr >= AW'(DEPTH);
    state_nxt = (state == IDLE) ? (|req ? ISSUE : IDLE) :
                (state == ISSUE) ? (we_l ? IDLE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      id <= 1'b0;
      we_l <= 1'b0;
      oor <= 1'b0;
      gnt <= '0;
      err <= '0;
      rvalid <= '0;
      rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt <= '0;
      err <= '0;
      rvalid <= '0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
      if (state == IDLE && |req) begin
        id <= sel;
        last <= sel;
        we_l <= sel_we;
        oor <= sel_oor;
        gnt[sel] <= 1'b1;
        err[sel] <= sel_oor;
        // out-of-range accesses never touch the memory pins
        if (!sel_oor) begin
          mem_addr <= sel_addr;
          mem_wdata <= sel_wdata;
          mem_write <= sel_we;
          mem_read <= ~sel_we;
        end
      end
      if (state == WAIT) begin
        rvalid[id] <= 1'b1;
        rdata <= oor ? '0 : mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a registered-read memory model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req = 2'b11, we = 2'b00;
  logic [31:0] addr0 = 32'd1, addr1 = 32'd2, wdata0 = '0, wdata1 = '0;
  logic [1:0] gnt, err, rvalid;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_write, mem_read;
  logic [31:0] mem [32];
  int checks = 0, errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .err(err), .rvalid(rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[1] <= 32'h11;
      mem[2] <= 32'h22;
    end
    if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr[4:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " gnt"}, 64'(gnt), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " rvalid"}, 64'(rvalid), 64'd0);
    chk({tag, " rdata"}, 64'(rdata), 64'd0);
    chk({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, " strobes"}, 64'({mem_write, mem_read}), 64'd0);
  endtask

  initial begin
    mem_rdata = '0;
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    // both ports read continuously; port 0 wins first
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("cont gnt %0d", i), 64'(gnt), 64'(2'b01 << (i % 2)));
      chk($sformatf("cont rd strobe %0d", i), 64'(mem_read), 64'd1);
      chk($sformatf("cont addr %0d", i), 64'(mem_addr), (i % 2) ? 64'd2 : 64'd1);
      if (i == 3) req = 2'b00;
      step();
      chk($sformatf("cont strobe off %0d", i), 64'({mem_read, gnt}), 64'd0);
      step();
      chk($sformatf("cont rvalid %0d", i), 64'(rvalid), 64'(2'b01 << (i % 2)));
      chk($sformatf("cont rdata %0d", i), 64'(rdata), (i % 2) ? 64'h22 : 64'h11);
    end
    // port 0 write then read back
    req = 2'b01; we = 2'b01; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
    step();
    chk("wr gnt", 64'(gnt), 64'b01);
    chk("wr strobe", 64'({mem_write, mem_read}), 64'b10);
    chk("wr addr", 64'(mem_addr), 64'd5);
    chk("wr data", 64'(mem_wdata), 64'hDEADBEEF);
    req = 2'b00;
    step();
    chk("wr done", 64'({mem_write, gnt}), 64'd0);
    req = 2'b01; we = 2'b00;
    step();
    chk("rd gnt", 64'(gnt), 64'b01);
    chk("rd strobe", 64'({mem_write, mem_read}), 64'b01);
    req = 2'b00;
    step();
    chk("rd early rvalid", 64'(rvalid), 64'd0);
    step();
    chk("rd rvalid", 64'(rvalid), 64'b01);
    chk("rd rdata", 64'(rdata), 64'hDEADBEEF);
    // out-of-range read and write on port 1
    req = 2'b10; we = 2'b00; addr1 = 32'd32;
    step();
    chk("oor rd gnt", 64'(gnt), 64'b10);
    chk("oor rd err", 64'(err), 64'b10);
    chk("oor rd strobe", 64'({mem_write, mem_read}), 64'd0);
    req = 2'b00;
    step();
    step();
    chk("oor rd rvalid", 64'(rvalid), 64'b10);
    chk("oor rd rdata", 64'(rdata), 64'd0);
    req = 2'b10; we = 2'b10; addr1 = 32'hFFFFFFFF; wdata1 = 32'h5A5A5A5A;
    step();
    chk("oor wr gnt", 64'(gnt), 64'b10);
    chk("oor wr err", 64'(err), 64'b10);
    chk("oor wr strobe", 64'({mem_write, mem_read}), 64'd0);
    req = 2'b00;
    step();
    chk("oor wr err off", 64'(err), 64'd0);
    // reset while waiting for read data
    req = 2'b10; we = 2'b00; addr1 = 32'd2;
    step();
    chk("mid gnt", 64'(gnt), 64'b10);
    req = 2'b00;
    step();
    rst_n = 1'b0;
    #1;
    chk_zero("mid reset");
    step();
    chk("mid no rvalid", 64'(rvalid), 64'd0);
    rst_n = 1'b1;
    req = 2'b10;
    step();
    chk("post gnt", 64'(gnt), 64'b10);
    req = 2'b00;
    step();
    step();
    chk("post rvalid", 64'(rvalid), 64'b10);
    chk("post rdata", 64'(rdata), 64'h22);
    // port 0 holds a write request for 6 cycles
    req = 2'b01; we = 2'b01; addr0 = 32'd7; wdata0 = 32'h0BADF00D;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("held gnt %0d", i), 64'(gnt), (i % 2) ? 64'd0 : 64'b01);
      chk($sformatf("held wr %0d", i), 64'(mem_write), (i % 2) ? 64'd0 : 64'd1);
    end
    req = 2'b00;
    step();
    chk("held mem", 64'(mem[7]), 64'h0BADF00D);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port 32-word data memory. It sits between two masters and the memory's Address/Write_Data/MemWrite/MemRead/Read_Data pins. Port 0 is the CPU load/store stage and port 1 is the debug/DMA loader. It serialises accesses with round-robin priority, issues exactly one memory strobe per transaction, and returns read data with a valid pulse after the memory's registered one-cycle read latency.

## Interface
- DEPTH, 32: number of memory words; valid word addresses are 0..DEPTH-1.
- AW, 32: address width.
- DW, 32: data width.

- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  per-port request; must be held with addr/wdata/we stable until that port's gnt.
- we  in  2  per-port direction: 1 = write, 0 = read.
- addr0, addr1  in  AW each  per-port word address.
- wdata0, wdata1  in  DW each  per-port write data.
- gnt  out  2  one-cycle pulse: the request was accepted and issued.
- err  out  2  one-cycle pulse coincident with gnt when addr >= DEPTH.
- rvalid  out  2  one-cycle pulse: rdata holds the read result for that port.
- rdata  out  DW  read data, shared by both ports and qualified by rvalid.
- mem_addr  out  AW  to memory Address.
- mem_wdata  out  DW  to memory Write_Data.
- mem_write  out  1  to memory MemWrite.
- mem_read  out  1  to memory MemRead.
- mem_rdata  in  DW  from memory Read_Data, valid the cycle after the mem_read edge.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets state=IDLE and last=1, so port 0 wins the first contention.
- FSM states:
  - IDLE: if no req, stay in IDLE. Otherwise select a port: the single requester, or if both request, the port != last. Latch addr, wdata, we and id. Set last=id. Pulse gnt[id]. Go to ISSUE.
  - IDLE, in-range request: drive mem_addr and mem_wdata, and assert mem_write=we or mem_read=!we.
  - IDLE, out-of-range request (addr >= DEPTH, compared on the full AW bits): no strobe; pulse err[id].
  - ISSUE: deassert the strobes. A write, in or out of range, goes to IDLE. A read goes to WAIT.
  - WAIT: set rdata=mem_rdata for an in-range read, or 0 for an out-of-range read. Pulse rvalid[id]. Go to IDLE.
- req is ignored in ISSUE and WAIT. The requester drops req after seeing gnt; a req still high in the following IDLE is treated as a new request.
- mem_addr and mem_wdata hold their last value when idle. Only the strobes qualify them.
- Only one transaction is outstanding at a time. Throughput is one write per 2 cycles and one read per 3 cycles.
- Asynchronous reset mid-transaction drops it: no rvalid, state=IDLE. A write strobe already sampled by the memory is not undone.

## Timing
- Edge E0, in IDLE, samples req. During the cycle after E0: gnt, err and the memory strobe are high.
- Edge E1: the memory performs the write or read.
- Read: rvalid and rdata are high during the cycle after E2, giving a latency of 2 cycles from gnt to rvalid.
- Next request sampled: at E2 after a write, at E3 after a read.
- Simultaneous requests: the loser keeps req high and is granted at the next IDLE sample, so strict alternation holds while both requesters stay busy.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=2'b11 -> all outputs 0. The first grant after release goes to port 0.
- Single write then read, port 0:
  - Write addr=5, wdata=32'hDEADBEEF -> gnt[0] and mem_write pulse 1 cycle, mem_addr=5.
  - Then read addr=5 -> rvalid[0] pulses 2 cycles after gnt[0], rdata=32'hDEADBEEF.
- Contention: both ports read continuously (addr0=1 holding 32'h11, addr1=2 holding 32'h22) -> grants alternate 0,1,0,1. rvalid alternates with rdata 32'h11, 32'h22.
- Out of range: port 1 reads addr=32 -> err[1] together with gnt[1], no mem_read pulse, then rvalid[1] with rdata=0. Port 1 writes addr=32'hFFFFFFFF -> err[1], no mem_write pulse.
- Reset mid-read: assert rst_n=0 during WAIT -> no rvalid, outputs 0. After release, a port 1 request is granted normally.
- Held req: port 0 keeps req high for 6 cycles on writes -> gnt[0] every 2 cycles, each with exactly one mem_write pulse.
